// File: rtl/led_pwm_pkg.sv
// Shared register map and channel mode encoding for the LED PWM peripheral.
package led_pwm_pkg;

  localparam int unsigned ADDR_ENABLE      = 0;
  localparam int unsigned ADDR_MODE        = 1;
  localparam int unsigned ADDR_PRESCALE    = 2;
  localparam int unsigned ADDR_BLINK_HALF  = 3;
  localparam int unsigned ADDR_DUTY_BASE   = 4;

  localparam int unsigned BLINK_HALF_WIDTH = 16;

  typedef enum logic {
    MODE_STEADY = 1'b0,
    MODE_BLINK  = 1'b1
  } mode_e;

endpackage

// File: rtl/led_pwm_timebase.sv
// Shared prescaler, PWM period counter and blink phase generator for all channels.
// Registered counters; tick, period_end and phase are valid in the current cycle.
module led_pwm_timebase
  import led_pwm_pkg::*;
#(
  parameter int PWM_WIDTH      = 8,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PRESCALE_WIDTH-1:0]   prescale_i,
  input  logic [BLINK_HALF_WIDTH-1:0] blink_half_i,
  input  logic                        prescale_wr_i,
  input  logic                        blink_wr_i,
  output logic                        tick_o,
  output logic [PWM_WIDTH-1:0]        pwm_cnt_o,
  output logic                        period_end_o,
  output logic                        phase_o
);

  logic [PRESCALE_WIDTH-1:0]   pre_cnt_q, pre_cnt_d;
  logic [PWM_WIDTH-1:0]        pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_HALF_WIDTH-1:0] blink_cnt_q, blink_cnt_d;
  logic                        phase_q, phase_d;
  logic                        tick;
  logic                        period_end;

  assign tick       = (pre_cnt_q == prescale_i);
  assign period_end = tick & (&pwm_cnt_q);

  always_comb begin
    pre_cnt_d = pre_cnt_q + 1'b1;
    if (prescale_wr_i || tick) begin
      pre_cnt_d = '0;
    end

    pwm_cnt_d = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
    end

    // A BLINK_HALF write or a zero half-period parks the blinker in the on phase.
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (blink_wr_i || (blink_half_i == '0)) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (period_end) begin
      if (blink_cnt_q == blink_half_i - 1'b1) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt_q   <= '0;
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign tick_o       = tick;
  assign pwm_cnt_o    = pwm_cnt_q;
  assign period_end_o = period_end;
  assign phase_o      = phase_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped multi-channel LED driver: register file, shadowed per-channel duty, PWM compare.
// Reads return data one cycle after sel; LED pins are registered, one clock after counter state.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int NUM_LEDS       = 4,
  parameter int PWM_WIDTH      = 8,
  parameter int PRESCALE_WIDTH = 16,
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic [NUM_LEDS-1:0]   led
);

  logic [NUM_LEDS-1:0]         enable_q, enable_d;
  logic [NUM_LEDS-1:0]         mode_q, mode_d;
  logic [PRESCALE_WIDTH-1:0]   prescale_q, prescale_d;
  logic [BLINK_HALF_WIDTH-1:0] blink_half_q, blink_half_d;
  logic [PWM_WIDTH-1:0]        duty_sh_q  [NUM_LEDS];
  logic [PWM_WIDTH-1:0]        duty_sh_d  [NUM_LEDS];
  logic [PWM_WIDTH-1:0]        duty_act_q [NUM_LEDS];
  logic [PWM_WIDTH-1:0]        duty_act_d [NUM_LEDS];
  logic [DATA_WIDTH-1:0]       rdata_q, rdata_d, rd_mux;
  logic                        rvalid_q, rvalid_d;
  logic [NUM_LEDS-1:0]         led_q, led_d;

  logic                        wr_en, rd_en;
  logic [31:0]                 addr_w;
  logic                        prescale_wr, blink_wr;
  logic                        tick, period_end, phase;
  logic [PWM_WIDTH-1:0]        pwm_cnt;
  logic                        unused_sig;

  assign wr_en       = sel & we;
  assign rd_en       = sel & ~we;
  assign addr_w      = 32'(addr);
  assign prescale_wr = wr_en && (addr_w == ADDR_PRESCALE);
  assign blink_wr    = wr_en && (addr_w == ADDR_BLINK_HALF);
  assign unused_sig  = ^{tick, wdata};

  led_pwm_timebase #(
    .PWM_WIDTH      (PWM_WIDTH),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_timebase (
    .clk           (clk),
    .reset         (reset),
    .prescale_i    (prescale_q),
    .blink_half_i  (blink_half_q),
    .prescale_wr_i (prescale_wr),
    .blink_wr_i    (blink_wr),
    .tick_o        (tick),
    .pwm_cnt_o     (pwm_cnt),
    .period_end_o  (period_end),
    .phase_o       (phase)
  );

  always_comb begin
    enable_d     = enable_q;
    mode_d       = mode_q;
    prescale_d   = prescale_q;
    blink_half_d = blink_half_q;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      duty_sh_d[i] = duty_sh_q[i];
      // Active duty samples the pre-edge shadow, so a same-cycle write waits a full period.
      duty_act_d[i] = period_end ? duty_sh_q[i] : duty_act_q[i];
    end

    if (wr_en) begin
      if (addr_w == ADDR_ENABLE)     enable_d     = wdata[NUM_LEDS-1:0];
      if (addr_w == ADDR_MODE)       mode_d       = wdata[NUM_LEDS-1:0];
      if (addr_w == ADDR_PRESCALE)   prescale_d   = wdata[PRESCALE_WIDTH-1:0];
      if (addr_w == ADDR_BLINK_HALF) blink_half_d = wdata[BLINK_HALF_WIDTH-1:0];
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        if (addr_w == ADDR_DUTY_BASE + i) duty_sh_d[i] = wdata[PWM_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (addr_w == ADDR_ENABLE)     rd_mux = DATA_WIDTH'(enable_q);
    if (addr_w == ADDR_MODE)       rd_mux = DATA_WIDTH'(mode_q);
    if (addr_w == ADDR_PRESCALE)   rd_mux = DATA_WIDTH'(prescale_q);
    if (addr_w == ADDR_BLINK_HALF) rd_mux = DATA_WIDTH'(blink_half_q);
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      if (addr_w == ADDR_DUTY_BASE + i) rd_mux = DATA_WIDTH'(duty_sh_q[i]);
    end
    rdata_d  = rd_en ? rd_mux : rdata_q;
    rvalid_d = rd_en;
  end

  always_comb begin
    led_d = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      led_d[i] = enable_q[i]
               & ((&duty_act_q[i]) | (pwm_cnt < duty_act_q[i]))
               & ((mode_e'(mode_q[i]) == MODE_BLINK) ? phase : 1'b1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q     <= '0;
      mode_q       <= '0;
      prescale_q   <= '0;
      blink_half_q <= '0;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      led_q        <= '0;
    end else begin
      enable_q     <= enable_d;
      mode_q       <= mode_d;
      prescale_q   <= prescale_d;
      blink_half_q <= blink_half_d;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        duty_sh_q[i]  <= duty_sh_d[i];
        duty_act_q[i] <= duty_act_d[i];
      end
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      led_q        <= led_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign led    = led_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl: register access, duty, shadowing, blink, prescale, async reset.
module tb_led_pwm_ctrl;

  localparam int NL = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk    = 1'b0;
  logic          reset  = 1'b0;
  logic          sel    = 1'b0;
  logic          we     = 1'b0;
  logic [AW-1:0] addr   = '0;
  logic [DW-1:0] wdata  = '0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic [NL-1:0] led;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  led_pwm_ctrl #(
    .NUM_LEDS       (NL),
    .PWM_WIDTH      (8),
    .PRESCALE_WIDTH (16),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .rvalid (rvalid),
    .led    (led)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = AW'(a); wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int a, input logic [31:0] exp);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = AW'(a);
    @(negedge clk);
    sel = 1'b0;
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    chk(tag, rdata, exp);
    @(negedge clk);
    chk({tag, "_rvalid_off"}, 32'(rvalid), 32'd0);
  endtask

  task automatic count_high(input int b, input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (led[b]) cnt++;
    end
  endtask

  // Returns on the first sample where led[b] goes 0 -> 1.
  task automatic wait_rise(input int b, input int bound, output logic found);
    logic prev;
    prev  = led[b];
    found = 1'b0;
    for (int k = 0; k < bound && !found; k++) begin
      @(negedge clk);
      if (!prev && led[b]) found = 1'b1;
      prev = led[b];
    end
  endtask

  // From a rising sample of led[2], rewrite PRESCALE=3 at sample wk and measure the high run.
  task automatic run_with_prescale_write(input int wk, output int run);
    logic done;
    run  = 0;
    done = 1'b0;
    for (int k = 1; k < 1100 && !done; k++) begin
      @(negedge clk);
      if (k == wk) begin
        sel = 1'b1; we = 1'b1; addr = AW'(2); wdata = 32'd3;
      end
      if (k == wk + 1) begin
        sel = 1'b0; we = 1'b0;
      end
      if (!led[2]) begin
        run  = k;
        done = 1'b1;
      end
    end
    sel = 1'b0; we = 1'b0;
  endtask

  initial begin
    int   c;
    int   run;
    logic found;

    // Reset and idle
    repeat (4) @(negedge clk);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_led", 32'(led), 32'd0);
    rd_chk("rd_enable_rst", 0, 32'd0);

    // Duty sweep on channel 0
    wr(2, 32'd0);
    wr(0, 32'hFFFF_FFF1);
    rd_chk("rd_enable", 0, 32'd1);
    wr(4, 32'd64);
    repeat (520) @(negedge clk);
    count_high(0, 256, c);
    chk("duty64", 32'(c), 32'd64);
    wr(4, 32'd255);
    repeat (520) @(negedge clk);
    count_high(0, 256, c);
    chk("duty255", 32'(c), 32'd256);
    wr(4, 32'd0);
    repeat (520) @(negedge clk);
    count_high(0, 256, c);
    chk("duty0", 32'(c), 32'd0);

    // Shadowing: rewrite duty mid-period
    wr(4, 32'd64);
    repeat (520) @(negedge clk);
    wait_rise(0, 600, found);
    chk("shadow_rise", 32'(found), 32'd1);
    c = 1;
    for (int k = 1; k < 256; k++) begin
      @(negedge clk);
      if (led[0]) c++;
      if (k == 100) begin
        sel = 1'b1; we = 1'b1; addr = AW'(4); wdata = 32'd192;
      end
      if (k == 101) begin
        sel = 1'b0; we = 1'b0;
      end
    end
    chk("shadow_cur_period", 32'(c), 32'd64);
    count_high(0, 256, c);
    chk("shadow_next_period", 32'(c), 32'd192);
    rd_chk("rd_duty0", 4, 32'd192);

    // Blink on channel 1
    wr(5, 32'd255);
    rd_chk("rd_duty1_shadow", 5, 32'd255);
    repeat (260) @(negedge clk);
    wr(1, 32'd2);
    wr(0, 32'd2);
    wr(3, 32'hABCD_0002);
    wait_rise(1, 2000, found);
    chk("blink_rise", 32'(found), 32'd1);
    c = 1;
    repeat (511) begin
      @(negedge clk);
      if (led[1]) c++;
    end
    chk("blink_on", 32'(c), 32'd512);
    count_high(1, 512, c);
    chk("blink_off", 32'(c), 32'd0);
    count_high(1, 512, c);
    chk("blink_on2", 32'(c), 32'd512);
    rd_chk("rd_blink_half", 3, 32'd2);
    rd_chk("rd_mode", 1, 32'd2);
    wr(20, 32'hFFFF_FFFF);
    rd_chk("rd_unmapped20", 20, 32'd0);
    rd_chk("rd_unmapped8", 8, 32'd0);
    wr(3, 32'd0);
    repeat (3) @(negedge clk);
    count_high(1, 300, c);
    chk("blink_half0_steady", 32'(c), 32'd300);

    // Async reset while blinking
    wr(3, 32'd2);
    repeat (10) @(negedge clk);
    chk("pre_reset_led1", 32'(led[1]), 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_led", 32'(led), 32'd0);
    chk("async_rvalid", 32'(rvalid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    rd_chk("post_rst_enable", 0, 32'd0);
    rd_chk("post_rst_mode", 1, 32'd0);
    rd_chk("post_rst_blink_half", 3, 32'd0);
    rd_chk("post_rst_duty0", 4, 32'd0);
    rd_chk("post_rst_duty1", 5, 32'd0);
    chk("post_rst_led", 32'(led), 32'd0);

    // Prescale on channel 2
    wr(2, 32'd3);
    wr(6, 32'd128);
    wr(0, 32'd4);
    rd_chk("rd_prescale", 2, 32'd3);
    repeat (2100) @(negedge clk);
    count_high(2, 1024, c);
    chk("prescale3_duty128", 32'(c), 32'd512);
    wait_rise(2, 1100, found);
    chk("prescale_rise1", 32'(found), 32'd1);
    run_with_prescale_write(98, run);
    chk("prescale_wr_on_tick", 32'(run), 32'd512);
    wait_rise(2, 1100, found);
    chk("prescale_rise2", 32'(found), 32'd1);
    run_with_prescale_write(99, run);
    chk("prescale_wr_restart", 32'(run), 32'd513);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
